// File: rtl/fu_ls_buf.sv
// Load/store functional-unit buffer: holds up to DEPTH memory ops, issues them to the
// LSQ in allocation order, collects load data and hands results to writeback in order.
module fu_ls_buf #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4,
    parameter int SQ_IDX_LEN = 3,
    parameter int TAG_LEN    = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  squash,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_store,
    input  logic [2:0]            in_funct3,
    input  logic [XLEN-1:0]       in_base,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [XLEN-1:0]       in_data,
    input  logic [SQ_IDX_LEN-1:0] in_sq_pos,
    input  logic [TAG_LEN-1:0]    in_tag,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_store,
    output logic [XLEN-1:0]       req_addr,
    output logic [XLEN-1:0]       req_data,
    output logic [1:0]            req_size,
    output logic [SQ_IDX_LEN-1:0] req_sq_pos,
    input  logic                  rsp_valid,
    input  logic [XLEN-1:0]       rsp_data,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [TAG_LEN-1:0]    wb_tag,
    output logic [XLEN-1:0]       wb_result,
    output logic                  wb_misalign
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int DW = IW + 2;

    typedef enum logic [1:0] {S_FREE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t                  st       [DEPTH];
    logic                    e_store  [DEPTH];
    logic [2:0]              e_funct3 [DEPTH];
    logic [XLEN-1:0]         e_addr   [DEPTH];
    logic [XLEN-1:0]         e_data   [DEPTH];
    logic [SQ_IDX_LEN-1:0]   e_sq_pos [DEPTH];
    logic [TAG_LEN-1:0]      e_tag    [DEPTH];
    logic [XLEN-1:0]         e_result [DEPTH];
    logic                    e_mis    [DEPTH];

    logic [PW-1:0] alloc_ptr, head_ptr;
    logic [DW-1:0] drop_cnt;

    logic [IW-1:0] alloc_idx, head_idx;
    assign alloc_idx = alloc_ptr[IW-1:0];
    assign head_idx  = head_ptr[IW-1:0];

    // Full when the indices meet but the wrap bits differ.
    assign in_ready = !((alloc_ptr[IW] != head_ptr[IW]) && (alloc_idx == head_idx));

    logic [XLEN-1:0] in_addr;
    logic            in_mis, accept;
    assign in_addr = in_base + in_imm;
    assign in_mis  = ((in_funct3[1:0] == 2'd1) && in_addr[0]) ||
                     ((in_funct3[1:0] == 2'd2) && (in_addr[1:0] != 2'b00));
    assign accept  = in_valid && in_ready && !squash;

    // Oldest REQ and oldest WAIT entries, searched from the head so issue and
    // completion follow allocation order; misaligned entries are skipped naturally.
    logic          req_found, wait_found;
    logic [IW-1:0] req_idx, wait_idx, idx;
    logic [DW-1:0] n_wait;
    always_comb begin
        req_found  = 1'b0;
        req_idx    = '0;
        wait_found = 1'b0;
        wait_idx   = '0;
        n_wait     = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_idx + IW'(i);
            if (!req_found && st[idx] == S_REQ) begin
                req_found = 1'b1;
                req_idx   = idx;
            end
            if (!wait_found && st[idx] == S_WAIT) begin
                wait_found = 1'b1;
                wait_idx   = idx;
            end
            if (st[idx] == S_WAIT) n_wait = n_wait + DW'(1);
        end
    end

    assign req_valid  = req_found;
    assign req_store  = e_store[req_idx];
    assign req_addr   = e_addr[req_idx];
    assign req_data   = e_data[req_idx];
    assign req_size   = e_funct3[req_idx][1:0];
    assign req_sq_pos = e_sq_pos[req_idx];

    assign wb_valid    = (st[head_idx] == S_DONE);
    assign wb_tag      = e_tag[head_idx];
    assign wb_result   = e_result[head_idx];
    assign wb_misalign = e_mis[head_idx];

    logic req_fire, wb_fire, rsp_hit, rsp_drop;
    assign req_fire = req_valid && req_ready;
    assign wb_fire  = wb_valid && wb_ready;
    assign rsp_drop = rsp_valid && (drop_cnt != '0);
    assign rsp_hit  = rsp_valid && (drop_cnt == '0) && wait_found;

    function automatic logic [XLEN-1:0] ld_ext(input logic [2:0] f3, input logic [XLEN-1:0] d);
        case (f3[1:0])
            2'd0:    return {{(XLEN-8){~f3[2] & d[7]}}, d[7:0]};
            2'd1:    return {{(XLEN-16){~f3[2] & d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            alloc_ptr <= '0;
            head_ptr  <= '0;
            drop_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                st[i]       <= S_FREE;
                e_store[i]  <= 1'b0;
                e_funct3[i] <= '0;
                e_addr[i]   <= '0;
                e_data[i]   <= '0;
                e_sq_pos[i] <= '0;
                e_tag[i]    <= '0;
                e_result[i] <= '0;
                e_mis[i]    <= 1'b0;
            end
        end else if (squash) begin
            // Loads already at the LSQ (including one issued this cycle) will still
            // answer; count them so their responses are discarded later.
            alloc_ptr <= '0;
            head_ptr  <= '0;
            drop_cnt  <= drop_cnt + n_wait + DW'(req_fire && !req_store)
                         - DW'(rsp_valid && (drop_cnt != '0 || n_wait != '0));
            for (int i = 0; i < DEPTH; i++) st[i] <= S_FREE;
        end else begin
            if (rsp_drop) drop_cnt <= drop_cnt - DW'(1);
            if (accept) begin
                st[alloc_idx]       <= in_mis ? S_DONE : S_REQ;
                e_store[alloc_idx]  <= in_store;
                e_funct3[alloc_idx] <= in_funct3;
                e_addr[alloc_idx]   <= in_addr;
                e_data[alloc_idx]   <= in_data;
                e_sq_pos[alloc_idx] <= in_sq_pos;
                e_tag[alloc_idx]    <= in_tag;
                e_result[alloc_idx] <= '0;
                e_mis[alloc_idx]    <= in_mis;
                alloc_ptr           <= alloc_ptr + PW'(1);
            end
            if (req_fire) st[req_idx] <= e_store[req_idx] ? S_DONE : S_WAIT;
            if (rsp_hit) begin
                st[wait_idx]       <= S_DONE;
                e_result[wait_idx] <= ld_ext(e_funct3[wait_idx], rsp_data);
            end
            if (wb_fire) begin
                st[head_idx] <= S_FREE;
                head_ptr     <= head_ptr + PW'(1);
            end
        end
    end
endmodule
